// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer: models MDU latency with a busy counter, owns HI/LO, raises D-stage stall.
// Define MDU_MADD_EN to enable madd/maddu (ops 7/8) accumulate into {HI,LO}.
module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

  logic signed [63:0] rs_ext, rt_ext, prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] rs_sg, rt_sg, quo_s, rem_s;
  logic        [31:0] quo_u, rem_u;
  logic               div_zero, op_is_md;

  assign rs_ext   = {{32{rs[31]}}, rs};
  assign rt_ext   = {{32{rt[31]}}, rt};
  assign prod_s   = rs_ext * rt_ext;
  assign prod_u   = {32'd0, rs} * {32'd0, rt};
  assign rs_sg    = rs;
  assign rt_sg    = rt;
  assign div_zero = (rt == 32'd0);
  // Divider outputs are muxed off for rt==0 so the pending result keeps HI/LO.
  assign quo_s    = div_zero ? 32'sd0 : rs_sg / rt_sg;
  assign rem_s    = div_zero ? 32'sd0 : rs_sg % rt_sg;
  assign quo_u    = div_zero ? 32'd0 : rs / rt;
  assign rem_u    = div_zero ? 32'd0 : rs % rt;
  assign op_is_md = (op >= 4'd1) && (op <= 4'd8);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            4'd1: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = RUN;
            end
            4'd2: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = RUN;
            end
            4'd3: begin
              pend_hi_d = div_zero ? hi_q : rem_s;
              pend_lo_d = div_zero ? lo_q : quo_s;
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = RUN;
            end
            4'd4: begin
              pend_hi_d = div_zero ? hi_q : rem_u;
              pend_lo_d = div_zero ? lo_q : quo_u;
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = RUN;
            end
            4'd5: hi_d = rs;
            4'd6: lo_d = rs;
`ifdef MDU_MADD_EN
            4'd7: begin
              {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + prod_s;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = RUN;
            end
            4'd8: begin
              {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + prod_u;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = RUN;
            end
`endif
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    pend_hi_q <= pend_hi_d;
    pend_lo_q <= pend_lo_d;
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      assert (!(start && op_is_md && state_q == RUN))
        else $error("mdu_sequencer: MD op issued while unit busy");
    end
  end

  // Stall uses only registered busy and E-stage issue; ops 7/8 count even without madd support.
  assign stall = md_use_d & (busy_q | (start & op_is_md));
  assign busy  = busy_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: expected {HI,LO} queued at issue, compared when busy drops.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, md_use_d;
  logic [3:0]  op;
  logic [31:0] rs, rt;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int checks = 0;
  int passes = 0;
  logic [63:0] sb[$];
  logic [63:0] exp_hl;

  mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .md_use_d(md_use_d), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                        input logic [63:0] hl);
    logic [63:0] p;
    logic [31:0] ma, mb, q, r;
    case (o)
      4'd1: begin
        p = {32'd0, a} * {32'd0, b};
        if (a[31]) p = p - {b, 32'd0};
        if (b[31]) p = p - {a, 32'd0};
        return p;
      end
      4'd2: return {32'd0, a} * {32'd0, b};
      4'd3: begin
        if (b == 32'd0) return hl;
        ma = a[31] ? -a : a;
        mb = b[31] ? -b : b;
        q  = ma / mb;
        r  = ma % mb;
        if (a[31] ^ b[31]) q = -q;
        if (a[31]) r = -r;
        return {r, q};
      end
      4'd4: return (b == 32'd0) ? hl : {a % b, a / b};
      4'd5: return {a, hl[31:0]};
      4'd6: return {hl[63:32], a};
`ifdef MDU_MADD_EN
      4'd7: return hl + model(4'd1, a, b, hl);
      4'd8: return hl + model(4'd2, a, b, hl);
`endif
      default: return hl;
    endcase
  endfunction

  function automatic int latency(input logic [3:0] o);
    case (o)
      4'd1, 4'd2: return 5;
      4'd3, 4'd4: return 10;
`ifdef MDU_MADD_EN
      4'd7, 4'd8: return 5;
`endif
      default: return 0;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where busy is first low again.
  task automatic do_op(input string name, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] expv, input int n);
    int cyc;
    logic [63:0] e;
    sb.push_back(expv);
    exp_hl = expv;
    start = 1'b1; op = o; rs = a; rt = b;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc !== n) $display("FAIL %s_busy_len: got %0d cycles, expected %0d", name, cyc, n);
    else passes++;
    e = sb.pop_front();
    checks++;
    if ({hi, lo} !== e) $display("FAIL %s_hilo: got %h_%h, expected %h_%h", name, hi, lo, e[63:32], e[31:0]);
    else passes++;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = 4'd0; rs = '0; rt = '0; md_use_d = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, hi, lo} !== 65'd0) $display("FAIL reset_state: got busy=%b hi=%h lo=%h, expected 0/0/0", busy, hi, lo);
    else passes++;
    reset = 1'b0;
    exp_hl = 64'd0;
    do_op("mthi_pre", 4'd5, 32'h5, 32'h0, {32'h5, 32'h0}, 0);
    do_op("mtlo_pre", 4'd6, 32'h6, 32'h0, {32'h5, 32'h6}, 0);
    start = 1'b1; op = 4'd3; rs = 32'd100; rt = 32'd7;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || hi !== 32'h5) $display("FAIL reset_pre_abort: got busy=%b hi=%h, expected 1/00000005", busy, hi);
    else passes++;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, hi, lo} !== 65'd0) $display("FAIL reset_abort: got busy=%b hi=%h lo=%h, expected 0/0/0", busy, hi, lo);
    else passes++;
    @(negedge clk);
    checks++;
    if ({busy, hi, lo} !== 65'd0) $display("FAIL reset_no_late_result: got busy=%b hi=%h lo=%h, expected 0/0/0", busy, hi, lo);
    else passes++;
    do_op("post_reset_mult", 4'd1, 32'd3, 32'd4, 64'd12, 5);
  endtask

  task automatic test_mult;
    do_op("mult", 4'd1, 32'd3, 32'hFFFFFFFE, {32'hFFFFFFFF, 32'hFFFFFFFA}, 5);
    do_op("multu", 4'd2, 32'd3, 32'hFFFFFFFE, {32'h00000002, 32'hFFFFFFFA}, 5);
  endtask

  task automatic test_div;
    do_op("div", 4'd3, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 10);
    do_op("divu", 4'd4, 32'd7, 32'd2, {32'd1, 32'd3}, 10);
    do_op("div_neg_divisor", 4'd3, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 10);
  endtask

  task automatic test_divzero;
    do_op("mthi", 4'd5, 32'h12345678, 32'h0, {32'h12345678, 32'hFFFFFFFD}, 0);
    do_op("div_by_zero", 4'd3, 32'd99, 32'd0, {32'h12345678, 32'hFFFFFFFD}, 10);
    do_op("divu_by_zero", 4'd4, 32'd99, 32'd0, {32'h12345678, 32'hFFFFFFFD}, 10);
  endtask

  task automatic test_stall;
    logic [63:0] e;
    md_use_d = 1'b1;
    start = 1'b1; op = 4'd1; rs = 32'd7; rt = 32'd6;
    sb.push_back(64'd42);
    exp_hl = 64'd42;
    #1;
    checks++;
    if (stall !== 1'b1) $display("FAIL stall_issue: got %b, expected 1", stall);
    else passes++;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    for (int i = 1; i <= 7; i++) begin
      #1;
      checks++;
      if (stall !== (i <= 5)) $display("FAIL stall_cycle%0d: got %b, expected %b", i, stall, (i <= 5));
      else passes++;
      @(negedge clk);
    end
    e = sb.pop_front();
    checks++;
    if ({hi, lo} !== e) $display("FAIL stall_mult_hilo: got %h_%h, expected %h_%h", hi, lo, e[63:32], e[31:0]);
    else passes++;
    md_use_d = 1'b0;
    start = 1'b1; op = 4'd1; rs = 32'd2; rt = 32'd9;
    sb.push_back(64'd18);
    exp_hl = 64'd18;
    for (int i = 0; i <= 7; i++) begin
      #1;
      checks++;
      if (stall !== 1'b0) $display("FAIL nostall_cycle%0d: got %b, expected 0", i, stall);
      else passes++;
      @(negedge clk);
      start = 1'b0; op = 4'd0;
    end
    e = sb.pop_front();
    checks++;
    if ({hi, lo} !== e) $display("FAIL nostall_mult_hilo: got %h_%h, expected %h_%h", hi, lo, e[63:32], e[31:0]);
    else passes++;
    md_use_d = 1'b1;
    start = 1'b1; op = 4'd8; #1;
    checks++;
    if (stall !== 1'b1) $display("FAIL stall_op8: got %b, expected 1", stall);
    else passes++;
    op = 4'd9; #1;
    checks++;
    if (stall !== 1'b0) $display("FAIL stall_op9: got %b, expected 0", stall);
    else passes++;
    @(negedge clk);
    start = 1'b0; op = 4'd0; md_use_d = 1'b0;
    checks++;
    if ({busy, hi, lo} !== {1'b0, 64'd18}) $display("FAIL op9_no_effect: got busy=%b hi=%h lo=%h, expected 0/00000000/00000012", busy, hi, lo);
    else passes++;
  endtask

  task automatic test_madd;
    do_op("mtlo_acc", 4'd6, 32'hFFFFFFFF, 32'h0, {32'h0, 32'hFFFFFFFF}, 0);
    do_op("mthi_acc", 4'd5, 32'h0, 32'h0, {32'h0, 32'hFFFFFFFF}, 0);
`ifdef MDU_MADD_EN
    do_op("madd", 4'd7, 32'd1, 32'd1, {32'd1, 32'd0}, 5);
    do_op("maddu", 4'd8, 32'hFFFFFFFF, 32'd2, {32'd2, 32'hFFFFFFFE}, 5);
`else
    do_op("madd_off", 4'd7, 32'd1, 32'd1, {32'h0, 32'hFFFFFFFF}, 0);
    do_op("maddu_off", 4'd8, 32'd1, 32'd1, {32'h0, 32'hFFFFFFFF}, 0);
`endif
  endtask

  task automatic test_back_to_back;
    logic [3:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      o = 4'($urandom_range(1, 8));
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if (i % 3 == 0) b = b >> $urandom_range(16, 31);
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
      do_op($sformatf("b2b%0d_op%0d", i, o), o, a, b, model(o, a, b, exp_hl), latency(o));
    end
  endtask

  initial begin
    exp_hl = 64'd0;
    test_reset;
    test_mult;
    test_div;
    test_divzero;
    test_stall;
    test_madd;
    test_back_to_back;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
